// File: rtl/img_pkg.sv
// Shared constants and types for the image frame sender and the CNN input loader.
package img_pkg;

  localparam logic [7:0]  HDR_SYNC0      = 8'hA5;
  localparam logic [7:0]  HDR_SYNC1      = 8'h5A;
  localparam int unsigned IMG_BYTES_DFLT = 784;
  localparam int unsigned IDX_W          = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_WAIT_ROM,
    ST_SEND,
    ST_WAIT_TX,
    ST_CSUM,
    ST_FIN
  } state_e;

  // Which part of the frame the byte in flight belongs to.
  typedef enum logic [1:0] {
    K_HDR,
    K_PAY,
    K_CSUM
  } byte_kind_e;

endpackage

// File: rtl/img_frame_sender_if.sv
// Control, status and image-ROM bus of the image frame sender.
interface img_frame_sender_if
  import img_pkg::*;
#(
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned ADDR_W = 12
) ();

  logic              start;
  logic [SEL_W-1:0]  img_sel;
  logic              abort;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_rdata;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [IDX_W-1:0]  byte_cnt;

  modport master (
    output start, img_sel, abort, rom_rdata,
    input  rom_addr, busy, done, aborted, byte_cnt
  );

  modport slave (
    input  start, img_sel, abort, rom_rdata,
    output rom_addr, busy, done, aborted, byte_cnt
  );

endinterface

// File: rtl/uart_send.sv
// 8N1 UART transmitter: one byte per uart_en pulse, uart_tx_busy high for the whole frame.
module uart_send #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_en,
  input  logic [7:0] uart_din,
  output logic       uart_tx_busy,
  output logic       uart_txd
);

  localparam int unsigned BAUD_CNT = CLK_FREQ / UART_BPS;
  localparam int unsigned CNT_W    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;

  logic [8:0]       shift_q;
  logic [3:0]       bit_q;
  logic [CNT_W-1:0] baud_q;
  logic             busy_q;
  logic             txd_q;

  // bit_q counts completed bit periods: start, 8 data, stop.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      shift_q <= '1;
      bit_q   <= '0;
      baud_q  <= '0;
      busy_q  <= 1'b0;
      txd_q   <= 1'b1;
    end else if (!busy_q) begin
      if (uart_en) begin
        shift_q <= {1'b1, uart_din};
        bit_q   <= '0;
        baud_q  <= '0;
        busy_q  <= 1'b1;
        txd_q   <= 1'b0;
      end
    end else if (baud_q == CNT_W'(BAUD_CNT - 1)) begin
      baud_q <= '0;
      if (bit_q == 4'd9) begin
        busy_q <= 1'b0;
        txd_q  <= 1'b1;
      end else begin
        txd_q   <= shift_q[0];
        shift_q <= {1'b1, shift_q[8:1]};
        bit_q   <= bit_q + 4'd1;
      end
    end else begin
      baud_q <= baud_q + CNT_W'(1);
    end
  end

  assign uart_tx_busy = busy_q;
  assign uart_txd     = txd_q;

endmodule

// File: rtl/img_frame_sender.sv
// Streams one ROM-resident image over the UART with optional sync header and checksum trailer.
module img_frame_sender
  import img_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned UART_BPS  = 115200,
  parameter int unsigned IMG_BYTES = IMG_BYTES_DFLT,
  parameter int unsigned NUM_IMG   = 4,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned ROM_LAT   = 1,
  parameter bit          HDR_EN    = 1'b1,
  parameter bit          CSUM_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  img_frame_sender_if.slave bus,
  output logic              uart_txd
);

  state_e            state_q;
  byte_kind_e        kind_q;
  logic [SEL_W-1:0]  sel_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  byte_cnt_q;
  logic [1:0]        hdr_cnt_q;
  logic [1:0]        lat_cnt_q;
  logic [7:0]        byte_q;
  logic [7:0]        csum_q;
  logic [7:0]        uart_din_q;
  logic              uart_en_q;
  logic              tx_busy_q;
  logic              abort_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;

  logic              tx_busy;
  logic [SEL_W-1:0]  sel_c;
  logic              abort_req_c;
  logic              tx_fall_c;
  logic              last_pay_c;

  assign sel_c       = (32'(bus.img_sel) >= NUM_IMG) ? SEL_W'(NUM_IMG - 1) : bus.img_sel;
  assign abort_req_c = abort_q | bus.abort;
  assign tx_fall_c   = tx_busy_q & ~tx_busy;
  assign last_pay_c  = (idx_q == IDX_W'(IMG_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      kind_q     <= K_HDR;
      sel_q      <= '0;
      base_q     <= '0;
      rom_addr_q <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      hdr_cnt_q  <= '0;
      lat_cnt_q  <= '0;
      byte_q     <= '0;
      csum_q     <= '0;
      uart_din_q <= '0;
      uart_en_q  <= 1'b0;
      tx_busy_q  <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      uart_en_q <= 1'b0;
      done_q    <= 1'b0;
      tx_busy_q <= tx_busy;
      if (state_q != ST_IDLE) abort_q <= abort_q | bus.abort;

      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            sel_q      <= sel_c;
            base_q     <= ADDR_W'(32'(sel_c) * IMG_BYTES);
            idx_q      <= '0;
            byte_cnt_q <= '0;
            hdr_cnt_q  <= '0;
            csum_q     <= '0;
            abort_q    <= 1'b0;
            aborted_q  <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= HDR_EN ? ST_HDR : ST_FETCH;
          end
        end
        ST_HDR: begin
          if (abort_req_c) begin
            aborted_q <= 1'b1;
            state_q   <= ST_FIN;
          end else begin
            byte_q  <= (hdr_cnt_q == 2'd0) ? HDR_SYNC0 :
                       (hdr_cnt_q == 2'd1) ? HDR_SYNC1 : 8'(sel_q);
            kind_q  <= K_HDR;
            state_q <= ST_SEND;
          end
        end
        ST_FETCH: begin
          if (abort_req_c) begin
            aborted_q <= 1'b1;
            state_q   <= ST_FIN;
          end else begin
            rom_addr_q <= base_q + ADDR_W'(idx_q);
            lat_cnt_q  <= '0;
            state_q    <= ST_WAIT_ROM;
          end
        end
        // rom_addr is registered, so data is valid ROM_LAT cycles after the first WAIT_ROM cycle.
        ST_WAIT_ROM: begin
          if (abort_req_c) begin
            aborted_q <= 1'b1;
            state_q   <= ST_FIN;
          end else if (lat_cnt_q == 2'(ROM_LAT)) begin
            byte_q  <= bus.rom_rdata;
            kind_q  <= K_PAY;
            state_q <= ST_SEND;
          end else begin
            lat_cnt_q <= lat_cnt_q + 2'd1;
          end
        end
        ST_SEND: begin
          if (!tx_busy) begin
            uart_en_q  <= 1'b1;
            uart_din_q <= byte_q;
            if (kind_q == K_PAY) begin
              csum_q     <= csum_q + byte_q;
              byte_cnt_q <= byte_cnt_q + 16'd1;
            end
            state_q <= ST_WAIT_TX;
          end
        end
        ST_WAIT_TX: begin
          if (tx_fall_c) begin
            if (abort_req_c) begin
              aborted_q <= 1'b1;
              state_q   <= ST_FIN;
            end else begin
              case (kind_q)
                K_HDR: begin
                  if (hdr_cnt_q == 2'd2) begin
                    state_q <= ST_FETCH;
                  end else begin
                    hdr_cnt_q <= hdr_cnt_q + 2'd1;
                    state_q   <= ST_HDR;
                  end
                end
                K_PAY: begin
                  if (last_pay_c) begin
                    state_q <= CSUM_EN ? ST_CSUM : ST_FIN;
                  end else begin
                    idx_q   <= idx_q + 16'd1;
                    state_q <= ST_FETCH;
                  end
                end
                default: state_q <= ST_FIN;
              endcase
            end
          end
        end
        ST_CSUM: begin
          if (abort_req_c) begin
            aborted_q <= 1'b1;
            state_q   <= ST_FIN;
          end else begin
            byte_q  <= csum_q;
            kind_q  <= K_CSUM;
            state_q <= ST_SEND;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.aborted  = aborted_q;
  assign bus.byte_cnt = byte_cnt_q;

  uart_send #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) u_uart_send (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .uart_en      (uart_en_q),
    .uart_din     (uart_din_q),
    .uart_tx_busy (tx_busy),
    .uart_txd     (uart_txd)
  );

endmodule

// File: tb/tb_img_frame_sender.sv
// Scoreboard bench for img_frame_sender: four configurations, UART line decoded and compared byte by byte.
`timescale 1ns/1ps
module tb_img_frame_sender;

  localparam int unsigned CLK_FREQ = 400;
  localparam int unsigned UART_BPS = 100;
  localparam int unsigned BAUD     = CLK_FREQ / UART_BPS;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned IB_A = 784, IB_B = 16, IB_C = 16, IB_D = 32;
  localparam int unsigned LAT_A = 1, LAT_B = 1, LAT_C = 3, LAT_D = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  int         cur;
  logic       start_r;
  logic [2:0] sel_r;
  logic       abort_r;
  bit         mon_en;
  int         tests;
  int         fails;
  int         done_cnt = 0;
  int         ovl_cnt  = 0;
  byte unsigned exp_q[$];

  img_frame_sender_if #(.SEL_W(2), .ADDR_W(ADDR_W)) if_a ();
  img_frame_sender_if #(.SEL_W(2), .ADDR_W(ADDR_W)) if_b ();
  img_frame_sender_if #(.SEL_W(3), .ADDR_W(ADDR_W)) if_c ();
  img_frame_sender_if #(.SEL_W(2), .ADDR_W(ADDR_W)) if_d ();
  logic txd_a, txd_b, txd_c, txd_d;

  assign if_a.start = start_r & (cur == 0);  assign if_a.abort = abort_r & (cur == 0);
  assign if_b.start = start_r & (cur == 1);  assign if_b.abort = abort_r & (cur == 1);
  assign if_c.start = start_r & (cur == 2);  assign if_c.abort = abort_r & (cur == 2);
  assign if_d.start = start_r & (cur == 3);  assign if_d.abort = abort_r & (cur == 3);
  assign if_a.img_sel = sel_r[1:0];
  assign if_b.img_sel = sel_r[1:0];
  assign if_c.img_sel = sel_r;
  assign if_d.img_sel = sel_r[1:0];

  img_frame_sender #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .IMG_BYTES(IB_A), .NUM_IMG(4),
    .ADDR_W(ADDR_W), .SEL_W(2), .ROM_LAT(LAT_A), .HDR_EN(1'b1), .CSUM_EN(1'b1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a), .uart_txd(txd_a));
  img_frame_sender #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .IMG_BYTES(IB_B), .NUM_IMG(4),
    .ADDR_W(ADDR_W), .SEL_W(2), .ROM_LAT(LAT_B), .HDR_EN(1'b0), .CSUM_EN(1'b0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b), .uart_txd(txd_b));
  img_frame_sender #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .IMG_BYTES(IB_C), .NUM_IMG(4),
    .ADDR_W(ADDR_W), .SEL_W(3), .ROM_LAT(LAT_C), .HDR_EN(1'b1), .CSUM_EN(1'b1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c), .uart_txd(txd_c));
  img_frame_sender #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .IMG_BYTES(IB_D), .NUM_IMG(4),
    .ADDR_W(ADDR_W), .SEL_W(2), .ROM_LAT(LAT_D), .HDR_EN(1'b1), .CSUM_EN(1'b1))
    dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d), .uart_txd(txd_d));

  function automatic logic [7:0] rom_f(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  // Behavioural synchronous ROMs with a 3-deep read pipeline; the tap sets the latency.
  logic [7:0] rp_a [3], rp_b [3], rp_c [3], rp_d [3];
  always @(posedge clk) begin
    rp_a[0] <= rom_f(if_a.rom_addr); rp_a[1] <= rp_a[0]; rp_a[2] <= rp_a[1];
    rp_b[0] <= rom_f(if_b.rom_addr); rp_b[1] <= rp_b[0]; rp_b[2] <= rp_b[1];
    rp_c[0] <= rom_f(if_c.rom_addr); rp_c[1] <= rp_c[0]; rp_c[2] <= rp_c[1];
    rp_d[0] <= rom_f(if_d.rom_addr); rp_d[1] <= rp_d[0]; rp_d[2] <= rp_d[1];
  end
  assign if_a.rom_rdata = rp_a[LAT_A-1];
  assign if_b.rom_rdata = rp_b[LAT_B-1];
  assign if_c.rom_rdata = rp_c[LAT_C-1];
  assign if_d.rom_rdata = rp_d[LAT_D-1];

  logic txd_m, busy_m, done_m, aborted_m;
  int   cnt_m, addr_m;
  always_comb begin
    txd_m = txd_a; busy_m = if_a.busy; done_m = if_a.done; aborted_m = if_a.aborted;
    cnt_m = int'(if_a.byte_cnt); addr_m = int'(if_a.rom_addr);
    case (cur)
      1: begin txd_m = txd_b; busy_m = if_b.busy; done_m = if_b.done; aborted_m = if_b.aborted;
               cnt_m = int'(if_b.byte_cnt); addr_m = int'(if_b.rom_addr); end
      2: begin txd_m = txd_c; busy_m = if_c.busy; done_m = if_c.done; aborted_m = if_c.aborted;
               cnt_m = int'(if_c.byte_cnt); addr_m = int'(if_c.rom_addr); end
      3: begin txd_m = txd_d; busy_m = if_d.busy; done_m = if_d.done; aborted_m = if_d.aborted;
               cnt_m = int'(if_d.byte_cnt); addr_m = int'(if_d.rom_addr); end
      default: ;
    endcase
  end

  always @(negedge clk) if (done_m === 1'b1) done_cnt <= done_cnt + 1;

  // A byte may never be handed to the transmitter while it is still busy.
  always @(posedge clk) begin
    if (rst_n && ((dut_a.uart_en_q & dut_a.tx_busy) | (dut_b.uart_en_q & dut_b.tx_busy) |
                  (dut_c.uart_en_q & dut_c.tx_busy) | (dut_d.uart_en_q & dut_d.tx_busy)))
      ovl_cnt <= ovl_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // UART line monitor: decodes 8N1 at mid-bit and pops the scoreboard.
  initial begin : monitor
    logic [7:0]   b;
    logic         stop_ok;
    byte unsigned e;
    forever begin
      @(negedge clk);
      if (txd_m === 1'b0) begin
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = txd_m;
        end
        repeat (BAUD) @(negedge clk);
        stop_ok = txd_m;
        if (mon_en) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL uart_extra: got byte %02h expected no byte", b);
          end else begin
            e = exp_q.pop_front();
            if (stop_ok !== 1'b1 || b !== e) begin
              fails++;
              $display("FAIL uart_byte: got %02h stop=%0b expected %02h stop=1", b, stop_ok, e);
            end
          end
        end
      end
    end
  end

  task automatic push_frame(input int ib, input bit hdr, input int sel_eff, input int npay,
                            input bit trailer);
    byte unsigned s;
    byte unsigned d;
    s = 8'h00;
    if (hdr) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'(sel_eff));
    end
    for (int i = 0; i < npay; i++) begin
      d = rom_f(ADDR_W'(sel_eff * ib + i));
      exp_q.push_back(d);
      s = s + d;
    end
    if (trailer) exp_q.push_back(s);
  endtask

  task automatic pulse_start(input int sel, input bit with_abort);
    @(posedge clk); #1;
    start_r = 1'b1; sel_r = 3'(sel); abort_r = with_abort;
    @(posedge clk); #1;
    start_r = 1'b0; abort_r = 1'b0;
  endtask

  task automatic finish_frame(input string name, input int exp_cnt, input int exp_ab,
                              input int d0, input int budget);
    int n;
    n = 0;
    while (done_m !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, int'(done_m === 1'b1), 1);
    check({name, "_byte_cnt"}, cnt_m, exp_cnt);
    check({name, "_aborted"}, int'(aborted_m), exp_ab);
    check({name, "_busy_at_done"}, int'(busy_m), 0);
    repeat (100) @(negedge clk);
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    check({name, "_bytes_left"}, exp_q.size(), 0);
    check({name, "_aborted_held"}, int'(aborted_m), exp_ab);
  endtask

  initial begin
    int d0;
    int n;
    tests = 0; fails = 0;
    rst_n = 1'b0; cur = 0; start_r = 1'b0; sel_r = '0; abort_r = 1'b0; mon_en = 1'b0;
    repeat (5) @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("init_txd", int'(txd_m), 1);
    check("init_busy", int'(busy_m), 0);
    check("init_byte_cnt", cnt_m, 0);

    // Reset in the middle of a frame truncates the line and clears all state.
    pulse_start(1, 1'b0);
    repeat (300) @(posedge clk);
    check("mid_frame_busy", int'(busy_m), 1);
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_txd", int'(txd_m), 1);
    check("rst_busy", int'(busy_m), 0);
    check("rst_done", int'(done_m), 0);
    check("rst_rom_addr", addr_m, 0);
    check("rst_byte_cnt", cnt_m, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_txd", int'(txd_m), 1);
    check("post_rst_busy", int'(busy_m), 0);
    mon_en = 1'b1;

    // Full default frame, image 0.
    cur = 0;
    push_frame(IB_A, 1'b1, 0, IB_A, 1'b1);
    d0 = done_cnt;
    pulse_start(0, 1'b0);
    finish_frame("t2", 784, 0, d0, 60000);

    // Bare payload, image 2, no framing.
    cur = 1;
    push_frame(IB_B, 1'b0, 2, IB_B, 1'b0);
    d0 = done_cnt;
    pulse_start(2, 1'b0);
    finish_frame("t3", 16, 0, d0, 3000);

    // Abort while payload byte 10 is on the line.
    cur = 3;
    push_frame(IB_D, 1'b1, 1, 11, 1'b0);
    d0 = done_cnt;
    pulse_start(1, 1'b0);
    n = 0;
    while (cnt_m != 11 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("t4_reach_byte10", cnt_m, 11);
    repeat (10) @(posedge clk);
    #1 abort_r = 1'b1;
    @(posedge clk); #1 abort_r = 1'b0;
    finish_frame("t4", 11, 1, d0, 3000);

    push_frame(IB_D, 1'b1, 3, IB_D, 1'b1);
    d0 = done_cnt;
    pulse_start(3, 1'b0);
    @(negedge clk);
    check("t4b_aborted_cleared", int'(aborted_m), 0);
    finish_frame("t4b", 32, 0, d0, 5000);

    // start+abort together in IDLE, then a start while busy: both leave the frame intact.
    push_frame(IB_D, 1'b1, 0, IB_D, 1'b1);
    d0 = done_cnt;
    pulse_start(0, 1'b1);
    @(negedge clk);
    check("t5_busy", int'(busy_m), 1);
    repeat (100) @(posedge clk);
    pulse_start(2, 1'b0);
    finish_frame("t5", 32, 0, d0, 5000);

    // Out-of-range select clamps to the last image; slow ROM.
    cur = 2;
    push_frame(IB_C, 1'b1, 3, IB_C, 1'b1);
    d0 = done_cnt;
    pulse_start(7, 1'b0);
    finish_frame("t6", 16, 0, d0, 3000);

    check("tx_overlap_cycles", ovl_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
